fifo_destino: RTL and testbench

- Output-side FIFO that consumes the words the VC0/VC1 pop arbiter produces.
- Two instances are used, D0 and D1. Each stores 6-bit words pushed one cycle after the arbiter pops; the push is the arbiter's delayed pop.
- It returns full and almost_full to the arbiter as back-pressure.
- It is drained by the downstream egress stage through a pop/valid interface.

---
 rtl/fifo_destino.sv | 69 ++++++
 tb/tb_fifo_destino.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_destino.sv
// fifo_destino: output-side FIFO draining the VC pop arbiter, with back-pressure flags.
// Ports: clk, reset_L (async active-low), push/data_in write side,
//        pop/data_out/valid_out read side (1-cycle registered read),
//        full/almost_full/empty/almost_empty status, sticky error, count occupancy.
module fifo_destino #(
  parameter int DATA_WIDTH         = 6,
  parameter int ADDR_WIDTH         = 3,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, err_q, err_d, push_ok, pop_ok;
  assign full         = cnt_q == CW'(DEPTH);
  assign empty        = cnt_q == '0;
  assign almost_full  = cnt_q >= CW'(ALMOST_FULL_LEVEL);
  assign almost_empty = cnt_q <= CW'(ALMOST_EMPTY_LEVEL);
  assign data_out     = dout_q;
  assign valid_out    = vld_q;
  assign error        = err_q;
  assign count        = cnt_q;
  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge;
  // an empty FIFO never reads through a word being written this edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  always_comb begin
    wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d   = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
    dout_d = pop_ok ? mem[rd_q] : dout_q;
    err_d  = err_q || (push && !push_ok) || (pop && empty);
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= pop_ok;
      err_q  <= err_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_q] <= data_in;
endmodule

// File: tb/tb_fifo_destino.sv
// tb_fifo_destino: directed vector bench for fifo_destino.
module tb_fifo_destino;
  logic       clk = 1'b0;
  logic       reset_L, push, pop;
  logic [5:0] data_in, data_out;
  logic       valid_out, full, almost_full, empty, almost_empty, error;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;

  fifo_destino dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [5:0] din;
    logic       pop;
    logic [3:0] cnt;
    logic [5:0] dout;
    logic       vld, full, af, empty, ae, err;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic [5:0] d, input logic q);
    push = p; data_in = d; pop = q;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " count"}, int'(count), 0);
    chk({tag, " empty"}, int'(empty), 1);
    chk({tag, " almost_empty"}, int'(almost_empty), 1);
    chk({tag, " full"}, int'(full), 0);
    chk({tag, " almost_full"}, int'(almost_full), 0);
    chk({tag, " error"}, int'(error), 0);
    chk({tag, " valid_out"}, int'(valid_out), 0);
    chk({tag, " data_out"}, int'(data_out), 0);
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) step(1'b1, 6'(i), 1'b0);
  endtask

  initial begin
    logic [5:0] q[$];
    logic [5:0] nxt;
    vecs[0]  = '{1, 6'h01, 0, 4'd1, 6'h00, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 6'h02, 0, 4'd2, 6'h00, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 6'h03, 0, 4'd3, 6'h00, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 6'h04, 0, 4'd4, 6'h00, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 6'h05, 0, 4'd5, 6'h00, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 6'h06, 0, 4'd6, 6'h00, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{1, 6'h07, 0, 4'd7, 6'h00, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{1, 6'h08, 0, 4'd8, 6'h00, 0, 1, 1, 0, 0, 0};
    vecs[8]  = '{0, 6'h00, 1, 4'd7, 6'h01, 1, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 6'h00, 1, 4'd6, 6'h02, 1, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 6'h00, 1, 4'd5, 6'h03, 1, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 6'h00, 1, 4'd4, 6'h04, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 6'h00, 1, 4'd3, 6'h05, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 6'h00, 1, 4'd2, 6'h06, 1, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 6'h00, 1, 4'd1, 6'h07, 1, 0, 0, 0, 1, 0};
    vecs[15] = '{0, 6'h00, 1, 4'd0, 6'h08, 1, 0, 0, 1, 1, 0};

    // Reset then idle
    do_reset();
    step(1'b0, 6'h00, 1'b0);
    check_reset_state("idle");

    // Fill then drain, table driven
    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].din, vecs[i].pop);
      chk($sformatf("v%0d count", i), int'(count), int'(vecs[i].cnt));
      chk($sformatf("v%0d data_out", i), int'(data_out), int'(vecs[i].dout));
      chk($sformatf("v%0d valid_out", i), int'(valid_out), int'(vecs[i].vld));
      chk($sformatf("v%0d full", i), int'(full), int'(vecs[i].full));
      chk($sformatf("v%0d almost_full", i), int'(almost_full), int'(vecs[i].af));
      chk($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].empty));
      chk($sformatf("v%0d almost_empty", i), int'(almost_empty), int'(vecs[i].ae));
      chk($sformatf("v%0d error", i), int'(error), int'(vecs[i].err));
    end
    step(1'b0, 6'h00, 1'b0);
    chk("idle after drain valid_out", int'(valid_out), 0);
    chk("idle after drain data_out holds", int'(data_out), 8);

    // Full + push + pop
    do_reset();
    fill8();
    step(1'b1, 6'h3F, 1'b1);
    chk("fullpp count", int'(count), 8);
    chk("fullpp data_out", int'(data_out), 1);
    chk("fullpp valid_out", int'(valid_out), 1);
    chk("fullpp error", int'(error), 0);
    for (int i = 2; i <= 9; i++) begin
      step(1'b0, 6'h00, 1'b1);
      chk($sformatf("fullpp drain%0d", i), int'(data_out), i == 9 ? 'h3F : i);
    end
    chk("fullpp end empty", int'(empty), 1);
    chk("fullpp end error", int'(error), 0);

    // Overflow
    do_reset();
    fill8();
    step(1'b1, 6'h2A, 1'b0);
    chk("ovf error", int'(error), 1);
    chk("ovf count", int'(count), 8);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 6'h00, 1'b1);
      chk($sformatf("ovf drain%0d", i), int'(data_out), i);
    end
    step(1'b0, 6'h00, 1'b1);
    chk("ovf extra pop valid_out", int'(valid_out), 0);
    chk("ovf extra pop data_out", int'(data_out), 8);
    chk("ovf error sticky", int'(error), 1);

    // Empty + push + pop
    do_reset();
    step(1'b1, 6'h15, 1'b1);
    chk("emptypp count", int'(count), 1);
    chk("emptypp valid_out", int'(valid_out), 0);
    chk("emptypp error", int'(error), 1);
    step(1'b0, 6'h00, 1'b1);
    chk("emptypp readback", int'(data_out), 'h15);
    chk("emptypp readback valid", int'(valid_out), 1);
    chk("emptypp count after", int'(count), 0);

    // Pointer wrap with alternating push/pop
    do_reset();
    nxt = 6'h10;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        q.push_back(nxt);
        step(1'b1, nxt, 1'b0);
        nxt++;
      end else begin
        step(1'b0, 6'h00, 1'b1);
        chk($sformatf("wrap pop%0d", i / 2), int'(data_out), int'(q.pop_front()));
        chk($sformatf("wrap valid%0d", i / 2), int'(valid_out), 1);
      end
    end
    chk("wrap error", int'(error), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'(i + 1), 1'b0);
    step(1'b0, 6'h00, 1'b1);
    chk("pre-reset count", int'(count), 2);
    #2 reset_L = 1'b0;
    #1;
    check_reset_state("async");
    #3 reset_L = 1'b1;
    step(1'b0, 6'h00, 1'b0);
    chk("post-reset count", int'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
